ps2_host_tx: RTL

Host-to-device PS/2 transmitter. It sends one command byte from the FPGA to a PS/2 keyboard or mouse: LED control 0xED, reset 0xFF, enable 0xF4, and so on. It uses the standard request-to-send sequence: inhibit the clock, drive the start bit, then shift out 8 data bits LSB-first, odd parity and a stop bit on device-generated clocks, and finally check the device's line ACK. It shares the open-drain `ps2_clk`/`ps2_dat` lines with the existing PS/2 receive logic, which should ignore traffic while `busy` is 1.

---
 rtl/ps2_host_tx_pkg.sv | 34 +++
 rtl/ps2_sync_edge.sv | 32 +++
 rtl/ps2_host_tx.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_pkg.sv
// ============================================================================
// ps2_host_tx_pkg : shared states, PS/2 command bytes and helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_XFER      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_e;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    localparam logic [3:0] ACK_EDGE = 4'd11;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_sync_edge.sv
// ============================================================================
// ps2_sync_edge : 2-flop synchronizer with falling-edge detect for one line
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic fall_o
);

    // [0] metastable stage, [1] synchronized value, [2] previous value.
    // Reset high matches idle lines so no spurious edge follows reset.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], d_i};
        end
    end

    assign q_o    = sync_q[1];
    assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

`default_nettype wire

// File: rtl/ps2_host_tx.sv
// ============================================================================
// ps2_host_tx : PS/2 host-to-device byte transmitter (request-to-send + ACK)
// Rev 1.0
// ============================================================================
`default_nettype none

module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 100,
    parameter int START_TIMEOUT  = 750000,
    parameter int BIT_TIMEOUT    = 100000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       send,
    input  logic [7:0] tx_data,
    inout  wire        ps2_clk,
    inout  wire        ps2_dat,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_W = $clog2(max_of(max_of(INHIBIT_CYCLES, START_CYCLES),
                                         max_of(START_TIMEOUT, BIT_TIMEOUT)) + 1);

    state_e             state_q, state_d;
    logic [9:0]         frame_q, frame_d;
    logic [3:0]         edges_q, edges_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clk_low_q, clk_low_d;
    logic               dat_low_q, dat_low_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               clk_s, clk_fall;
    logic               dat_s, dat_fall_unused;
    logic [3:0]         edge_num;

    ps2_sync_edge u_sync_clk (
        .clk    (CLOCK_50),
        .rst_n  (Resetn),
        .d_i    (ps2_clk),
        .q_o    (clk_s),
        .fall_o (clk_fall)
    );

    ps2_sync_edge u_sync_dat (
        .clk    (CLOCK_50),
        .rst_n  (Resetn),
        .d_i    (ps2_dat),
        .q_o    (dat_s),
        .fall_o (dat_fall_unused)
    );

    assign edge_num = edges_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        edges_d   = edges_q;
        cnt_d     = cnt_q;
        clk_low_d = clk_low_q;
        dat_low_d = dat_low_q;
        done_d    = 1'b0;
        error_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                if (send) begin
                    frame_d   = {1'b1, odd_parity(tx_data), tx_data};
                    edges_d   = 4'd0;
                    cnt_d     = '0;
                    clk_low_d = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    cnt_d     = '0;
                    dat_low_d = 1'b1;
                    state_d   = ST_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
                    clk_low_d = 1'b0;
                    cnt_d     = CNT_W'(START_TIMEOUT - 1);
                    state_d   = ST_XFER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_XFER: begin
                if (clk_fall) begin
                    cnt_d   = CNT_W'(BIT_TIMEOUT - 1);
                    edges_d = edge_num;
                    if (edge_num == ACK_EDGE) begin
                        if (dat_s) begin
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT_IDLE;
                        end
                    end else begin
                        // Edge 10 shifts out frame bit 9 (stop = 1), releasing data.
                        dat_low_d = ~frame_q[0];
                        frame_d   = {1'b0, frame_q[9:1]};
                    end
                end else if (cnt_q == '0) begin
                    error_d   = 1'b1;
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_s && dat_s) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (clk_fall) begin
                    cnt_d = CNT_W'(BIT_TIMEOUT - 1);
                end else if (cnt_q == '0) begin
                    error_d   = 1'b1;
                    clk_low_d = 1'b0;
                    dat_low_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                clk_low_d = 1'b0;
                dat_low_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= ST_IDLE;
            frame_q   <= '0;
            edges_q   <= '0;
            cnt_q     <= '0;
            clk_low_q <= 1'b0;
            dat_low_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            edges_q   <= edges_d;
            cnt_q     <= cnt_d;
            clk_low_q <= clk_low_d;
            dat_low_q <= dat_low_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign ps2_clk = clk_low_q ? 1'b0 : 1'bz;
    assign ps2_dat = dat_low_q ? 1'b0 : 1'bz;

    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule

`default_nettype wire
